dmem_responder: RTL

//  Data-memory target for the multicycle controller's dm_read/dm_write strobes. Accepts one

---
 rtl/dmem_responder_pkg.sv | 18 +
 rtl/dmem_array.sv | 30 +++
 rtl/dmem_responder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: access size codes, FSM states
// and the byte sign-extension used by loads.
package dmem_responder_pkg;

  localparam logic DM_SIZE_BYTE = 1'b0;
  localparam logic DM_SIZE_WORD = 1'b1;

  typedef enum logic [1:0] {
    DM_ST_IDLE = 2'd0,
    DM_ST_WAIT = 2'd1,
    DM_ST_DONE = 2'd2
  } dm_state_t;

  function automatic logic [31:0] sext_byte(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-laned data memory: DEPTH_BYTES/4 words, one write enable per lane,
// synchronous write and combinational read of a single aligned word.
module dmem_array #(
  parameter int unsigned DEPTH_BYTES = 1024
) (
  input  logic                               clk,
  input  logic [$clog2(DEPTH_BYTES/4)-1:0]   i_word_addr,
  input  logic [3:0]                         i_we,
  input  logic [31:0]                        i_wdata,
  output logic [31:0]                        o_rdata
);

  localparam int unsigned WORDS = DEPTH_BYTES / 4;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_mem [WORDS];

      always_ff @(posedge clk) begin
        if (i_we[gi]) begin
          r_mem[i_word_addr] <= i_wdata[8*gi +: 8];
        end
      end

      assign o_rdata[8*gi +: 8] = r_mem[i_word_addr];
    end
  endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for the multicycle controller: one load/store per transaction,
// fixed access latency, sign-extended load data and a single-cycle done/err pulse.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_dm_read,
  input  logic        i_dm_write,
  input  logic        i_size,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_ready,
  output logic [31:0] o_rdata,
  output logic        o_done,
  output logic        o_err,
  output logic        o_overrun
);

  localparam int unsigned AW       = $clog2(DEPTH_BYTES);
  localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  dm_state_t      r_state;
  dm_state_t      w_state_next;
  logic [3:0]     r_cnt;
  logic           r_is_write;
  logic           r_size;
  logic           r_fault;
  logic [AW-1:0]  r_addr;
  logic [31:0]    r_wdata;
  logic [31:0]    r_rdata;
  logic           r_overrun;

  logic           w_idle;
  logic           w_req_any;
  logic           w_accept;
  logic           w_in_fault;
  logic           w_cur_write;
  logic           w_cur_size;
  logic           w_cur_fault;
  logic [AW-1:0]  w_cur_addr;
  logic [31:0]    w_cur_wdata;
  logic           w_commit;
  logic [3:0]     w_we;
  logic [31:0]    w_mem_wdata;
  logic [31:0]    w_mem_rdata;
  logic [7:0]     w_byte;
  logic [31:0]    w_load_data;

  assign w_idle     = (r_state == DM_ST_IDLE);
  assign w_req_any  = i_dm_read | i_dm_write;
  assign w_accept   = w_idle & w_req_any;
  assign w_in_fault = (i_dm_read & i_dm_write)
                    | (i_addr >= 32'(DEPTH_BYTES))
                    | ((i_size == DM_SIZE_WORD) && (i_addr[1:0] != 2'b00));

  // With LATENCY=1 the commit happens on the accept edge, before the request
  // latches are loaded, so the live inputs stand in for them while IDLE.
  assign w_cur_write = w_idle ? i_dm_write       : r_is_write;
  assign w_cur_size  = w_idle ? i_size           : r_size;
  assign w_cur_fault = w_idle ? w_in_fault       : r_fault;
  assign w_cur_addr  = w_idle ? i_addr[AW-1:0]   : r_addr;
  assign w_cur_wdata = w_idle ? i_wdata          : r_wdata;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      DM_ST_IDLE: if (w_req_any) w_state_next = (LATENCY == 1) ? DM_ST_DONE : DM_ST_WAIT;
      DM_ST_WAIT: if (r_cnt == 4'd0) w_state_next = DM_ST_DONE;
      DM_ST_DONE: w_state_next = DM_ST_IDLE;
      default:    w_state_next = DM_ST_IDLE;
    endcase
  end

  // Memory and rdata update on the edge that enters DONE; reset cancels it.
  assign w_commit = (w_state_next == DM_ST_DONE) && (r_state != DM_ST_DONE) && !reset;

  always_comb begin
    w_we = 4'h0;
    if (w_commit && w_cur_write && !w_cur_fault) begin
      w_we = (w_cur_size == DM_SIZE_WORD) ? 4'hF : (4'b0001 << w_cur_addr[1:0]);
    end
  end

  assign w_mem_wdata = (w_cur_size == DM_SIZE_WORD) ? w_cur_wdata : {4{w_cur_wdata[7:0]}};

  dmem_array #(
    .DEPTH_BYTES (DEPTH_BYTES)
  ) u_array (
    .clk         (clk),
    .i_word_addr (w_cur_addr[AW-1:2]),
    .i_we        (w_we),
    .i_wdata     (w_mem_wdata),
    .o_rdata     (w_mem_rdata)
  );

  always_comb begin
    case (w_cur_addr[1:0])
      2'd0:    w_byte = w_mem_rdata[7:0];
      2'd1:    w_byte = w_mem_rdata[15:8];
      2'd2:    w_byte = w_mem_rdata[23:16];
      default: w_byte = w_mem_rdata[31:24];
    endcase
  end

  assign w_load_data = (w_cur_size == DM_SIZE_WORD) ? w_mem_rdata : sext_byte(w_byte);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= DM_ST_IDLE;
      r_cnt      <= 4'd0;
      r_is_write <= 1'b0;
      r_size     <= DM_SIZE_BYTE;
      r_fault    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      r_rdata    <= 32'd0;
      r_overrun  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_cnt      <= CNT_INIT;
        r_is_write <= i_dm_write;
        r_size     <= i_size;
        r_fault    <= w_in_fault;
        r_addr     <= i_addr[AW-1:0];
        r_wdata    <= i_wdata;
      end else if (r_state == DM_ST_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit && !w_cur_write && !w_cur_fault) begin
        r_rdata <= w_load_data;
      end
      if (!w_idle && w_req_any) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign o_ready   = w_idle;
  assign o_rdata   = r_rdata;
  assign o_done    = (r_state == DM_ST_DONE);
  assign o_err     = (r_state == DM_ST_DONE) && r_fault;
  assign o_overrun = r_overrun;

endmodule
